tx_os_inserter: RTL and testbench

TX_OS_INSERTER -- requirements
Module: tx_os_inserter

---
 rtl/tx_os_inserter.sv | 177 +++++++++++++++++
 tb/tb_tx_os_inserter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_os_inserter.sv
// tx_os_inserter: merges link-layer symbols with SKP and TS1/TS2 ordered
// sets ahead of the scrambler, one registered symbol per clock.
module tx_os_inserter #(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter logic [7:0]  RATE_ID      = 8'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_datak,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] ts_req,
    input  logic       link_pad,
    input  logic [7:0] link_num,
    input  logic [4:0] lane_num,
    input  logic [7:0] n_fts,
    output logic [7:0] data_out,
    output logic       is_kcode,
    output logic       data_in_TS_OS,
    output logic       os_active,
    output logic       skp_sent,
    output logic       ts_sent
);

    localparam logic [7:0]  K_COM   = 8'hBC;
    localparam logic [7:0]  K_SKP   = 8'h1C;
    localparam logic [7:0]  K_PAD   = 8'hF7;
    localparam logic [7:0]  TS1_ID  = 8'h4A;
    localparam logic [7:0]  TS2_ID  = 8'h45;
    localparam logic [10:0] SKP_LIM = 11'(SKP_INTERVAL);

    typedef enum logic [1:0] {S_DATA, S_SKP, S_TS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [10:0] skp_cnt_q, skp_cnt_d;
    logic        ts2_q, ts2_d;
    logic        pad_q, pad_d;
    logic [7:0]  link_q, link_d;
    logic [4:0]  lane_q, lane_d;
    logic [7:0]  nfts_q, nfts_d;
    logic [7:0]  dout_q, dout_d;
    logic        kout_q, kout_d;
    logic        tsos_q, tsos_d;
    logic        osact_q, osact_d;
    logic        skps_q, skps_d;
    logic        tss_q, tss_d;

    logic boundary, skp_pend, ts_want;

    always_comb begin
        boundary = (state_q == S_DATA)
                || (state_q == S_SKP && idx_q == 4'd3)
                || (state_q == S_TS && idx_q == 4'd15);
        skp_pend = skp_cnt_q >= SKP_LIM;
        ts_want  = ts_req[0] ^ ts_req[1];
        tx_ready = boundary && !skp_pend && !ts_want;

        state_d = state_q;
        idx_d   = idx_q + 4'd1;
        ts2_d   = ts2_q;
        pad_d   = pad_q;
        link_d  = link_q;
        lane_d  = lane_q;
        nfts_d  = nfts_q;

        // OS selection happens only between ordered sets
        if (boundary) begin
            idx_d = 4'd0;
            if (skp_pend) begin
                state_d = S_SKP;
            end else if (ts_want) begin
                state_d = S_TS;
                ts2_d   = ts_req[1];
                pad_d   = link_pad;
                link_d  = link_num;
                lane_d  = lane_num;
                nfts_d  = n_fts;
            end else begin
                state_d = S_DATA;
            end
        end

        dout_d  = 8'h00;
        kout_d  = 1'b0;
        tsos_d  = 1'b0;
        osact_d = 1'b0;
        skps_d  = 1'b0;
        tss_d   = 1'b0;

        unique case (state_d)
            S_DATA: begin
                if (tx_valid && tx_ready) begin
                    dout_d = tx_data;
                    kout_d = tx_datak;
                end
            end
            S_SKP: begin
                osact_d = 1'b1;
                kout_d  = 1'b1;
                dout_d  = (idx_d == 4'd0) ? K_COM : K_SKP;
                skps_d  = (idx_d == 4'd3);
            end
            S_TS: begin
                osact_d = 1'b1;
                tsos_d  = (idx_d != 4'd0);
                tss_d   = (idx_d == 4'd15);
                unique case (idx_d)
                    4'd0: begin
                        dout_d = K_COM;
                        kout_d = 1'b1;
                    end
                    4'd1: begin
                        dout_d = pad_q ? K_PAD : link_q;
                        kout_d = pad_q;
                    end
                    4'd2:    dout_d = {3'b000, lane_q};
                    4'd3:    dout_d = nfts_q;
                    4'd4:    dout_d = RATE_ID;
                    4'd5:    dout_d = 8'h00;
                    default: dout_d = ts2_q ? TS2_ID : TS1_ID;
                endcase
            end
            default: ;
        endcase

        if (state_d == S_SKP && idx_d == 4'd0)
            skp_cnt_d = 11'd0;
        else if (skp_cnt_q == 11'h7FF)
            skp_cnt_d = skp_cnt_q;
        else
            skp_cnt_d = skp_cnt_q + 11'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_DATA;
            idx_q     <= 4'd0;
            skp_cnt_q <= 11'd0;
            ts2_q     <= 1'b0;
            pad_q     <= 1'b0;
            link_q    <= 8'h00;
            lane_q    <= 5'd0;
            nfts_q    <= 8'h00;
            dout_q    <= 8'h00;
            kout_q    <= 1'b0;
            tsos_q    <= 1'b0;
            osact_q   <= 1'b0;
            skps_q    <= 1'b0;
            tss_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            skp_cnt_q <= skp_cnt_d;
            ts2_q     <= ts2_d;
            pad_q     <= pad_d;
            link_q    <= link_d;
            lane_q    <= lane_d;
            nfts_q    <= nfts_d;
            dout_q    <= dout_d;
            kout_q    <= kout_d;
            tsos_q    <= tsos_d;
            osact_q   <= osact_d;
            skps_q    <= skps_d;
            tss_q     <= tss_d;
        end
    end

    assign data_out      = dout_q;
    assign is_kcode      = kout_q;
    assign data_in_TS_OS = tsos_q;
    assign os_active     = osact_q;
    assign skp_sent      = skps_q;
    assign ts_sent       = tss_q;

endmodule

// File: tb/tb_tx_os_inserter.sv
// tb_tx_os_inserter: table vectors, directed corner sequences and random
// traffic checked against a queue-based symbol-stream model.
module tb_tx_os_inserter;

    localparam int INTV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_datak = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [1:0] ts_req = 2'b00;
    logic       link_pad = 1'b0;
    logic [7:0] link_num = 8'h00;
    logic [4:0] lane_num = 5'd0;
    logic [7:0] n_fts = 8'h00;
    logic [7:0] data_out;
    logic       is_kcode, data_in_TS_OS, os_active, skp_sent, ts_sent;

    always #5 clk = ~clk;

    tx_os_inserter #(.SKP_INTERVAL(INTV), .RATE_ID(8'h02)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_datak(tx_datak), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ts_req(ts_req), .link_pad(link_pad),
        .link_num(link_num), .lane_num(lane_num), .n_fts(n_fts),
        .data_out(data_out), .is_kcode(is_kcode),
        .data_in_TS_OS(data_in_TS_OS), .os_active(os_active),
        .skp_sent(skp_sent), .ts_sent(ts_sent)
    );

    typedef struct packed {
        logic [7:0] d;
        logic k, ts, os, ss, tss;
    } sym_t;

    typedef struct {
        logic [1:0] req;
        logic       pad;
        logic [7:0] link;
        logic [4:0] lane;
        logic [7:0] nfts;
        logic [7:0] d;
        logic       k, ts, tsent;
    } vec_t;

    sym_t       m_q[$];
    sym_t       m_exp;
    int         m_cnt;
    bit         xfer;
    logic [7:0] up_byte;
    int total = 0, bad = 0;
    int ready_low, skp_n, tsent_n;
    vec_t vt[32];
    logic [7:0] e1[16] = '{8'hBC, 8'h05, 8'h03, 8'h20, 8'h02, 8'h00,
        8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
    logic [7:0] e2[16] = '{8'hBC, 8'hF7, 8'h1F, 8'hFF, 8'h02, 8'h00,
        8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45};

    function automatic sym_t mk(logic [7:0] d, logic k, logic ts,
                                logic ss, logic tss);
        sym_t s;
        s.d = d; s.k = k; s.ts = ts; s.os = 1'b1; s.ss = ss; s.tss = tss;
        return s;
    endfunction

    function automatic logic [12:0] dut_vec();
        return {data_out, is_kcode, data_in_TS_OS, os_active,
                skp_sent, ts_sent};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_q.size() == 0 && m_cnt < INTV
            && !(ts_req == 2'b01 || ts_req == 2'b10);
    endfunction

    task automatic model_step();
        sym_t n;
        bit com;
        logic [7:0] id;
        com  = 1'b0;
        xfer = 1'b0;
        if (m_q.size() == 0) begin
            if (m_cnt >= INTV) begin
                com = 1'b1;
                m_q.push_back(mk(8'hBC, 1, 0, 0, 0));
                m_q.push_back(mk(8'h1C, 1, 0, 0, 0));
                m_q.push_back(mk(8'h1C, 1, 0, 0, 0));
                m_q.push_back(mk(8'h1C, 1, 0, 1, 0));
            end else if (ts_req == 2'b01 || ts_req == 2'b10) begin
                id = (ts_req == 2'b01) ? 8'h4A : 8'h45;
                m_q.push_back(mk(8'hBC, 1, 0, 0, 0));
                if (link_pad) m_q.push_back(mk(8'hF7, 1, 1, 0, 0));
                else          m_q.push_back(mk(link_num, 0, 1, 0, 0));
                m_q.push_back(mk({3'b000, lane_num}, 0, 1, 0, 0));
                m_q.push_back(mk(n_fts, 0, 1, 0, 0));
                m_q.push_back(mk(8'h02, 0, 1, 0, 0));
                m_q.push_back(mk(8'h00, 0, 1, 0, 0));
                for (int i = 6; i < 16; i++)
                    m_q.push_back(mk(id, 0, 1, 0, i == 15));
            end
        end
        if (m_q.size() > 0) begin
            n = m_q.pop_front();
        end else begin
            n = '0;
            if (tx_valid) begin
                n.d  = tx_data;
                n.k  = tx_datak;
                xfer = 1'b1;
            end
        end
        m_cnt = com ? 0 : ((m_cnt < 2047) ? m_cnt + 1 : 2047);
        m_exp = n;
    endtask

    task automatic cycle();
        @(negedge clk);
        check("ready", tx_ready, m_ready());
        if (!tx_ready) ready_low++;
        model_step();
        @(posedge clk);
        #1;
        check("sym", dut_vec(), m_exp);
        if (skp_sent) skp_n++;
        if (ts_sent) tsent_n++;
        if (xfer) up_byte++;
        tx_data  = up_byte;
        tx_datak = (up_byte[4:0] == 5'h1C);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_now", dut_vec(), 13'h0);
        m_q.delete();
        m_cnt = 0;
        m_exp = '0;
        xfer  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", dut_vec(), 13'h0);
        rst      = 1'b1;
        up_byte  = 8'h00;
        tx_data  = 8'h00;
        tx_datak = 1'b0;
        ready_low = 0;
        skp_n     = 0;
        tsent_n   = 0;
    endtask

    initial begin : main
        logic [7:0] tsd[2];
        int nts, after;

        for (int i = 0; i < 16; i++) begin
            vt[i].req = 2'b01; vt[i].pad = 1'b0; vt[i].link = 8'h05;
            vt[i].lane = 5'd3; vt[i].nfts = 8'h20;
            vt[i].d = e1[i]; vt[i].k = (i == 0);
            vt[i].ts = (i != 0); vt[i].tsent = (i == 15);
            vt[i+16].req = 2'b10; vt[i+16].pad = 1'b1; vt[i+16].link = 8'h11;
            vt[i+16].lane = 5'h1F; vt[i+16].nfts = 8'hFF;
            vt[i+16].d = e2[i]; vt[i+16].k = (i < 2);
            vt[i+16].ts = (i != 0); vt[i+16].tsent = (i == 15);
        end

        #2;
        do_reset();

        // data stream with SKP insertion
        tx_valid = 1'b1;
        repeat (25) cycle();
        check("skp_ready_low", ready_low, 4);
        check("skp_pulses", skp_n, 1);
        tx_valid = 1'b0;

        // TS1 and TS2 symbol tables
        for (int t = 0; t < 32; t++) begin
            if (t % 16 == 0) begin
                do_reset();
                ts_req   = vt[t].req;
                link_pad = vt[t].pad;
                link_num = vt[t].link;
                lane_num = vt[t].lane;
                n_fts    = vt[t].nfts;
            end
            cycle();
            check("tbl_d", data_out, vt[t].d);
            check("tbl_flags", {is_kcode, data_in_TS_OS, os_active, ts_sent},
                  {vt[t].k, vt[t].ts, 1'b1, vt[t].tsent});
            if (t % 16 == 0) begin
                ts_req = 2'b00; link_pad = 1'b0; link_num = 8'hEE;
                lane_num = 5'd9; n_fts = 8'h77;
            end
        end

        // SKP between TS, and TS type change mid-OS
        do_reset();
        ts_req = 2'b01; link_pad = 1'b0; link_num = 8'h05;
        lane_num = 5'd3; n_fts = 8'h20;
        nts = 0; after = 0;
        for (int c = 1; c <= 60; c++) begin
            cycle();
            if (c == 8) ts_req = 2'b10;
            if (after == 1) check("skp_after_ts_com", data_out, 8'hBC);
            if (after == 2) check("skp_after_ts_skp", data_out, 8'h1C);
            if (after > 0) after++;
            if (ts_sent && nts < 2) begin
                tsd[nts] = data_out;
                if (nts == 0) after = 1;
                nts++;
            end
        end
        check("ts_count", nts, 2);
        check("ts_first_id", tsd[0], 8'h4A);
        check("ts_second_id", tsd[1], 8'h45);

        // reset in the middle of a TS
        do_reset();
        ts_req = 2'b01;
        repeat (10) cycle();
        check("pre_rst_sym9", data_out, 8'h4A);
        do_reset();
        ts_req = 2'b00;
        repeat (22) cycle();
        check("post_rst_no_ts", tsent_n, 0);
        check("post_rst_skp", skp_n, 1);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) ts_req = 2'($urandom);
            link_pad = 1'($urandom);
            link_num = 8'($urandom);
            lane_num = 5'($urandom);
            n_fts    = 8'($urandom);
            if (!(tx_valid && !xfer)) tx_valid = 1'($urandom);
            if (c == 700) do_reset();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
